// File: rtl/r5fp_sqrt_share.sv
// r5fp_sqrt_share: shares one sequential sqrt unit between NREQ lanes, one operation in flight.
// Build option R5FP_SQRT_SHARE_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module r5fp_sqrt_share #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int NREQ  = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*(EXP_W+SIG_W+1)-1:0]     req_a,
  input  logic [NREQ*3-1:0]                   req_rnd,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [ID_W-1:0]                     resp_id,
  output logic [EXP_W+SIG_W:0]                resp_z,
  output logic [7:0]                          resp_status,
  output logic [EXP_W+SIG_W:0]                sq_a,
  output logic [2:0]                          sq_rnd,
  output logic                                sq_strobe,
  input  logic                                sq_ready,
  input  logic                                sq_complete,
  input  logic [EXP_W+SIG_W:0]                sq_z,
  input  logic [7:0]                          sq_status
);

  localparam int W = EXP_W + SIG_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sq_a_q, sq_a_d;
  logic [2:0]      sq_rnd_q, sq_rnd_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    resp_z_q, resp_z_d;
  logic [7:0]      resp_status_q, resp_status_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic [W-1:0]    a_sel;
  logic [2:0]      rnd_sel;

`ifndef R5FP_SQRT_SHARE_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Winner search: first valid requester at or after the scan start, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef R5FP_SQRT_SHARE_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      cand = ID_W'((int'(rr_ptr_q) + k) % NREQ);
`endif
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    a_sel    = '0;
    rnd_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_oh[i] = grant_vld;
        a_sel       = req_a[i*W +: W];
        rnd_sel     = req_rnd[i*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sq_a_d        = sq_a_q;
    sq_rnd_d      = sq_rnd_q;
    id_d          = id_q;
    resp_z_d      = resp_z_q;
    resp_status_d = resp_status_q;
`ifndef R5FP_SQRT_SHARE_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    req_ready     = '0;

    case (state_q)
      ST_IDLE: begin
        if (sq_ready && grant_vld) begin
          req_ready = grant_oh;
          sq_a_d    = a_sel;
          sq_rnd_d  = rnd_sel;
          id_d      = grant_idx;
`ifndef R5FP_SQRT_SHARE_FIXED_PRIO_EN
          rr_ptr_d  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
`endif
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completions outside WAIT are stale or spurious and are dropped.
        if (sq_complete) begin
          resp_z_d      = sq_z;
          resp_status_d = sq_status;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sq_a_q        <= '0;
      sq_rnd_q      <= '0;
      id_q          <= '0;
      resp_z_q      <= '0;
      resp_status_q <= '0;
`ifndef R5FP_SQRT_SHARE_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sq_a_q        <= sq_a_d;
      sq_rnd_q      <= sq_rnd_d;
      id_q          <= id_d;
      resp_z_q      <= resp_z_d;
      resp_status_q <= resp_status_d;
`ifndef R5FP_SQRT_SHARE_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign sq_strobe   = (state_q == ST_ISSUE);
  assign resp_valid  = (state_q == ST_RESP);
  assign sq_a        = sq_a_q;
  assign sq_rnd      = sq_rnd_q;
  assign resp_id     = id_q;
  assign resp_z      = resp_z_q;
  assign resp_status = resp_status_q;

endmodule

// File: tb/tb_r5fp_sqrt_share.sv
// Scoreboard bench for r5fp_sqrt_share with a behavioural sqrt unit of fixed latency.
module tb_r5fp_sqrt_share;

  localparam int L = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [11:0]  req_rnd = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic [31:0]  resp_z;
  logic [7:0]   resp_status;
  logic [31:0]  sq_a;
  logic [2:0]   sq_rnd;
  logic         sq_strobe;
  logic         sq_ready;
  logic         sq_complete;
  logic [31:0]  sq_z;
  logic [7:0]   sq_status;

  always #5 clk = ~clk;

  r5fp_sqrt_share dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_rnd(req_rnd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_z(resp_z), .resp_status(resp_status),
    .sq_a(sq_a), .sq_rnd(sq_rnd), .sq_strobe(sq_strobe), .sq_ready(sq_ready),
    .sq_complete(sq_complete), .sq_z(sq_z), .sq_status(sq_status)
  );

  // Behavioural sqrt unit: table of known operands, status bit 4 = invalid, bit 0 = inexact.
  function automatic logic [39:0] sq_model(input logic [31:0] a);
    case (a)
      32'h40800000: return {32'h40000000, 8'h00};
      32'h41100000: return {32'h40400000, 8'h00};
      32'h3F800000: return {32'h3F800000, 8'h00};
      32'h3E800000: return {32'h3F000000, 8'h00};
      32'h40000000: return {32'h3FB504F3, 8'h01};
      32'h41800000: return {32'h40800000, 8'h00};
      32'hBF800000: return {32'h7FC00000, 8'h10};
      default:      return {32'hDEADBEEF, 8'hFF};
    endcase
  endfunction

  logic       m_busy;
  logic [1:0] m_cnt;
  logic [31:0] m_z;
  logic [7:0] m_st;
  logic       spur_cpl = 1'b0;

  assign sq_ready    = !m_busy;
  assign sq_complete = (m_busy && m_cnt == 2'd0) || spur_cpl;
  assign sq_z        = m_z;
  assign sq_status   = m_st;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= '0; m_z <= '0; m_st <= '0;
    end else if (sq_strobe && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= 2'(L - 1);
      {m_z, m_st} <= sq_model(sq_a);
    end else if (m_busy) begin
      if (m_cnt == 2'd0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 2'd1;
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] z;
    logic [7:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  logic [34:0] iss_q[$];
  exp_t        mon_e;
  logic [34:0] mon_i;
  logic [31:0] exp_z_r[4];
  logic [7:0]  exp_st_r[4];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: issue side and response side checked against queued expectations.
  always @(negedge clk) begin
    if (!reset && sq_strobe) begin
      if (iss_q.size() == 0) begin
        total++; bad++;
        $display("FAIL issue_unexpected: strobe with sq_a=%h and no pending grant", sq_a);
      end else begin
        mon_i = iss_q.pop_front();
        chk("issue_sq_a", sq_a, mon_i[34:3]);
        chk("issue_sq_rnd", sq_rnd, mon_i[2:0]);
      end
    end
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: id=%0d z=%h with empty scoreboard", resp_id, resp_z);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", resp_id, mon_e.id);
        chk("resp_z", resp_z, mon_e.z);
        chk("resp_status", resp_status, mon_e.st);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [2:0] rnd,
                         input logic [31:0] ez, input logic [7:0] es);
    req_a[id*32 +: 32]  = a;
    req_rnd[id*3 +: 3]  = rnd;
    exp_z_r[id]         = ez;
    exp_st_r[id]        = es;
  endtask

  task automatic wait_grant(input logic [3:0] eoh, input int g);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL grant_timeout: req_ready stayed 0, expected %b", eoh);
    end else begin
      chk("grant_onehot", req_ready, eoh);
      exp_q.push_back('{id: g[1:0], z: exp_z_r[g], st: exp_st_r[g]});
      iss_q.push_back({req_a[g*32 +: 32], req_rnd[g*3 +: 3]});
    end
  endtask

  task automatic issue_one(input int id, input logic [31:0] a, input logic [2:0] rnd,
                           input logic [31:0] ez, input logic [7:0] es);
    drive_edge();
    set_req(id, a, rnd, ez, es);
    req_valid[id] = 1'b1;
    wait_grant(4'b0001 << id, id);
    drive_edge();
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("strobe_after_grant", sq_strobe, 1);
    chk("ready_single_cycle", req_ready, 0);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_valid) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sq_strobe", sq_strobe, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_sq_a", sq_a, 0);
    chk("rst_sq_rnd", sq_rnd, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fair_oh[5];
    int         fair_id[5];
    bit         got;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    drive_edge();
    reset = 1'b0;

    // Spurious complete in IDLE
    drive_edge();
    spur_cpl = 1'b1;
    drive_edge();
    spur_cpl = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spurious_resp_valid", resp_valid, 0);
    end
    chk("spurious_no_ready", req_ready, 0);

    // Single request: 4.0 -> 2.0 from requester 2
    issue_one(2, 32'h40800000, 3'd0, 32'h40000000, 8'h00);
    wait_drain();

    // Reset while waiting on the unit
    issue_one(2, 32'h41800000, 3'd5, 32'h40800000, 8'h00);
    drive_edge();
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    drive_edge();
    spur_cpl = 1'b1;
    drive_edge();
    spur_cpl = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("late_cpl_no_resp", resp_valid, 0);
    end

    // Fairness: all four held valid
    drive_edge();
    set_req(0, 32'h3F800000, 3'd1, 32'h3F800000, 8'h00);
    set_req(1, 32'h41100000, 3'd2, 32'h40400000, 8'h00);
    set_req(2, 32'h3E800000, 3'd3, 32'h3F000000, 8'h00);
    set_req(3, 32'h40000000, 3'd4, 32'h3FB504F3, 8'h01);
`ifdef R5FP_SQRT_SHARE_FIXED_PRIO_EN
    fair_id = '{0, 0, 0, 0, 0};
`else
    fair_id = '{0, 1, 2, 3, 0};
`endif
    for (int n = 0; n < 5; n++) fair_oh[n] = 4'b0001 << fair_id[n];
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) wait_grant(fair_oh[n], fair_id[n]);
    drive_edge();
    req_valid = 4'b0000;
    wait_drain();

    // Backpressure: 9.0 from requester 1 held for 10 cycles, requester 0 waiting
    resp_ready = 1'b0;
    issue_one(1, 32'h41100000, 3'd4, 32'h40400000, 8'h00);
    drive_edge();
    set_req(0, 32'h3F800000, 3'd2, 32'h3F800000, 8'h00);
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("bp_resp_arrived", got, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_resp_z_hold", resp_z, 32'h40400000);
      chk("bp_resp_valid_hold", resp_valid, 1);
      chk("bp_no_grant", req_ready, 0);
    end
    drive_edge();
    resp_ready = 1'b1;
    wait_grant(4'b0001, 0);
    drive_edge();
    req_valid[0] = 1'b0;
    wait_drain();

    // Invalid operand: -1.0 from requester 3
    issue_one(3, 32'hBF800000, 3'd0, 32'h7FC00000, 8'h10);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
